// File: rtl/ul_acc_pipe.sv
// ul_acc_pipe: registered AND/OR/XOR/NOT unit with accumulator and op counter.
// Optional zero/parity flags are built only when UL_FLAGS_EN is defined.
module ul_acc_pipe #(
    parameter int               WIDTH    = 8,
    parameter int               CNT_W    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s,
    input  logic             acc_sel,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] op_cnt
`ifdef UL_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

    logic             accept;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] f;
    logic             cnt_full;

    // One-entry output stage: free when empty or being drained now.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign opa      = acc_sel ? acc : a;
    assign cnt_full = &op_cnt;

    // Fully decoded op select; every code is legal.
    always_comb begin
        f = '0;
        unique case (s)
            2'b00: f = opa & b;
            2'b01: f = opa | b;
            2'b10: f = opa ^ b;
            2'b11: f = ~opa;
        endcase
    end

    // Output valid: set on accept, cleared when drained with no refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_valid <= 1'b0;
        else if (accept)
            out_valid <= 1'b1;
        else if (out_ready)
            out_valid <= 1'b0;
    end

    // Result register loads only on accept and otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            result <= '0;
        else if (accept)
            result <= f;
    end

    // Accumulator: clear wins over the update from a same-cycle accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= ACC_INIT;
        else if (acc_clr)
            acc <= ACC_INIT;
        else if (accept)
            acc <= f;
    end

    // Saturating count of accepted transactions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_cnt <= '0;
        else if (accept && !cnt_full)
            op_cnt <= op_cnt + 1'b1;
    end

`ifdef UL_FLAGS_EN
    // Flags track the value written into result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero   <= 1'b1;
            parity <= 1'b0;
        end else if (accept) begin
            zero   <= (f == '0);
            parity <= ^f;
        end
    end
`endif

endmodule
